obstacle_filter: RTL and testbench
==================================

# obstacle_filter

Filters the centimetre distance stream from the ultrasonic ranging stage before the motor-control logic uses it. Each accepted sample goes into a power-of-two moving average. The averaged value feeds a hysteresis and debounce state machine that drives a single `stop` flag. A compile-time option adds a fail-safe stop when range samples stop arriving.

## Interface
- `WIDTH`, 20: bit width of the distance sample and the average, in cm.
- `AVG_LOG2`, 2: log2 of the averaging window; window N = 2^AVG_LOG2 samples.
- `STOP_CM`, 40: an average strictly below this value counts as a "near" sample.
- `CLEAR_CM`, 50: an average at or above this value counts as a "clear" sample. Must be ≥ STOP_CM.
- `HOLD_CNT`, 3: number of consecutive qualifying averages needed to change state. Must be ≥ 1.
- `TIMEOUT_CYC`, 20000000: number of `clk` cycles with no sample before a fault (0.2 s at 100 MHz).

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `dist_in`  in  WIDTH: distance sample in cm, unsigned.
- `dist_vld`  in  1: one-cycle strobe qualifying `dist_in`. May be high on consecutive cycles.
- `dist_avg`  out  WIDTH: registered moving average.
- `avg_vld`  out  1: one-cycle strobe qualifying `dist_avg`.
- `stop`  out  1: obstacle / fail-safe stop request.
- `fault`  out  1: sample timeout flag.

## Operation
- Ring buffer of N entries, a running sum of WIDTH+AVG_LOG2 bits, and a fill counter (0..N).
- On each `dist_vld`, in one step:
  - sum ← sum + `dist_in` − oldest entry;
  - `dist_in` overwrites the oldest entry;
  - the write pointer advances modulo N;
  - the fill counter saturates at N.
- The sum never overflows.
- `dist_avg` = sum >> AVG_LOG2 (floor). It is computed only once the fill counter equals N. No `avg_vld` is issued before the Nth sample.
- State machine, with a hold counter `hc` (0..HOLD_CNT−1):
  - **WARMUP** (`stop`=1): on the first `avg_vld`, go to HALT and evaluate that average under the HALT rules.
  - **HALT** (`stop`=1): on each `avg_vld`:
    - avg ≥ CLEAR_CM → `hc`++;
    - otherwise `hc`←0.
    - When `hc` would reach HOLD_CNT → go to RUN, `hc`←0.
  - **RUN** (`stop`=0): on each `avg_vld`:
    - avg < STOP_CM → `hc`++;
    - otherwise `hc`←0.
    - When `hc` would reach HOLD_CNT → go to HALT, `hc`←0.
- Averages in [STOP_CM, CLEAR_CM) reset `hc` in both HALT and RUN (hysteresis band).
- `fault` forces HALT and `hc`←0; a fault has priority over any `avg_vld` in the same cycle.
- `rst` mid-operation: clears the buffer, sum, pointer, fill counter, `hc` and the timeout counter, and enters WARMUP. Any sample in flight is discarded.

## Timing
- Reset values:
  - `dist_avg`=0, `avg_vld`=0, `fault`=0;
  - `stop`=1 (WARMUP);
  - all internal state zeroed.
- Latency from a `dist_vld` sampled at edge k:
  - sum updated at edge k;
  - `dist_avg`/`avg_vld` registered at edge k+1;
  - state and `stop` registered at edge k+2.
- Full throughput: one sample per cycle is accepted with no stall and no dropped strobe.
- `stop` changes only on the edge after an `avg_vld` cycle, or on a `fault`/`rst` edge.

## Configuration
- `OBST_TIMEOUT_EN` defined:
  - A cycle counter resets on each `dist_vld` and otherwise increments.
  - When it reaches TIMEOUT_CYC−1, `fault` is registered to 1 on the next edge, and the state machine is forced to HALT.
  - `fault` clears on the edge after the next `dist_vld`. Release from HALT then follows the normal HOLD_CNT rule.
- `OBST_TIMEOUT_EN` undefined: no timeout counter; `fault` is tied to 0.

## Test plan
- Warm-up then release: after reset, 6 samples of 100 spaced 10 cycles apart.
  - No `avg_vld` on samples 1–3; `dist_avg`=100 on sample 4.
  - `stop` stays 1 through sample 5; `stop` falls 2 edges after sample 6.
- Approach: from RUN with the window at 100, feed samples of 20.
  - Averages are 80, 60, 40, 20, 20, 20.
  - `stop` rises 2 edges after the 6th sample of 20; the average of 40 does not count as near.
- Hysteresis: in HALT, feed samples of 45 indefinitely → `stop` stays 1.
  - Then one sample of 60 inside a run of 45s → `hc` resets and `stop` stays 1.
- Back-to-back: `dist_vld` high for 8 consecutive cycles with values 0,4,8,…,28.
  - `avg_vld` high for 5 consecutive cycles with averages 6, 10, 14, 18, 22.
- Reset mid-run: assert `rst` for 1 cycle while in RUN.
  - Next cycle shows `stop`=1, `avg_vld`=0.
  - The next 3 samples produce no `avg_vld`.
- Timeout (`OBST_TIMEOUT_EN`, TIMEOUT_CYC=100): in RUN, withhold `dist_vld`.
  - `fault` and `stop` go to 1 exactly 100 edges after the last sample.
  - One sample of 100 clears `fault`; `stop` stays 1 until HOLD_CNT clear averages have been seen.

Source files
------------

// File: rtl/obstacle_filter.sv
// -----------------------------------------------------------------------------
// obstacle_filter
//
// Smooths the centimetre distance stream from the ultrasonic ranging stage and
// turns it into a debounced stop request for the motor-control logic.
//
//   dist_in/dist_vld -> power-of-two moving average -> dist_avg/avg_vld
//   dist_avg/avg_vld -> hysteresis + hold-count FSM -> stop
//
// Optional feature (macro OBST_TIMEOUT_EN): if no sample arrives for
// TIMEOUT_CYC cycles, fault is raised and the FSM is forced to HALT. Without
// the macro there is no timeout counter and fault is tied low.
//
// Strobe semantics: dist_vld and avg_vld are single-cycle qualifiers with no
// back-pressure. Data is meaningful only in a cycle where its strobe is high,
// and strobes may be high on consecutive cycles (one sample per clock).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   dist_in    in   WIDTH  distance sample in cm (unsigned)
//   dist_vld   in   1      strobe qualifying dist_in
//   dist_avg   out  WIDTH  registered moving average
//   avg_vld    out  1      strobe qualifying dist_avg
//   stop       out  1      obstacle / fail-safe stop request
//   fault      out  1      sample timeout flag
//   state_dbg  out  2      current FSM state (0 WARMUP, 1 HALT, 2 RUN)
// -----------------------------------------------------------------------------
module obstacle_filter #(
    parameter int WIDTH       = 20,
    parameter int AVG_LOG2    = 2,
    parameter int STOP_CM     = 40,
    parameter int CLEAR_CM    = 50,
    parameter int HOLD_CNT    = 3,
    parameter int TIMEOUT_CYC = 20000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dist_in,
    input  logic             dist_vld,
    output logic [WIDTH-1:0] dist_avg,
    output logic             avg_vld,
    output logic             stop,
    output logic             fault,
    output logic [1:0]       state_dbg
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam int HC_W   = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;

    localparam logic [WIDTH-1:0]  STOP_V  = WIDTH'(STOP_CM);
    localparam logic [WIDTH-1:0]  CLEAR_V = WIDTH'(CLEAR_CM);
    localparam logic [FILL_W-1:0] FULL_V  = FILL_W'(N);
    localparam logic [HC_W-1:0]   HC_LAST = HC_W'(HOLD_CNT - 1);

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_HALT   = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Moving average
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    ring [N];
    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]   fill;
    // Marks that the sum was updated on the previous edge, so the average
    // is registered exactly one edge after the sample.
    logic                smp_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ring[i] <= '0;
            end
            sum      <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            smp_pend <= 1'b0;
            dist_avg <= '0;
            avg_vld  <= 1'b0;
        end else begin
            smp_pend <= dist_vld;
            if (dist_vld) begin
                // Subtract the entry being overwritten; the sum is always
                // the exact total of the N ring entries, so it cannot
                // overflow SUM_W bits.
                sum          <= sum + SUM_W'(dist_in) - SUM_W'(ring[wr_ptr]);
                ring[wr_ptr] <= dist_in;
                wr_ptr       <= wr_ptr + 1'b1;
                if (fill != FULL_V) begin
                    fill <= fill + 1'b1;
                end
            end
            // fill already includes the sample that produced this sum.
            avg_vld <= smp_pend && (fill == FULL_V);
            if (smp_pend && (fill == FULL_V)) begin
                dist_avg <= sum[AVG_LOG2 +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample timeout
    // ------------------------------------------------------------------
    logic force_halt;

`ifdef OBST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
    logic            fault_q;
    logic            to_hit;

    // A sample arriving in the terminal cycle wins: no fault is raised.
    assign to_hit = !dist_vld && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (dist_vld) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                // Parks at the terminal count while samples stay absent.
                to_cnt <= to_cnt + 1'b1;
            end

            if (dist_vld) begin
                fault_q <= 1'b0;
            end else if (to_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    // HALT is entered on the same edge fault rises, and held while it stays.
    assign force_halt = to_hit || fault_q;
    assign fault      = fault_q;
`else
    assign force_halt = 1'b0;
    assign fault      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Hysteresis / debounce FSM
    // ------------------------------------------------------------------
    state_t          state, state_n;
    logic [HC_W-1:0] hc, hc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WARMUP;
            hc    <= '0;
        end else begin
            state <= state_n;
            hc    <= hc_n;
        end
    end

    always_comb begin
        state_n = state;
        hc_n    = hc;
        if (force_halt) begin
            state_n = S_HALT;
            hc_n    = '0;
        end else if (avg_vld) begin
            case (state)
                // The first average leaves WARMUP and is judged as in HALT.
                S_WARMUP, S_HALT: begin
                    state_n = S_HALT;
                    if (dist_avg >= CLEAR_V) begin
                        if (hc == HC_LAST) begin
                            state_n = S_RUN;
                            hc_n    = '0;
                        end else begin
                            hc_n = hc + 1'b1;
                        end
                    end else begin
                        hc_n = '0;
                    end
                end
                S_RUN: begin
                    if (dist_avg < STOP_V) begin
                        if (hc == HC_LAST) begin
                            state_n = S_HALT;
                            hc_n    = '0;
                        end else begin
                            hc_n = hc + 1'b1;
                        end
                    end else begin
                        hc_n = '0;
                    end
                end
                default: begin
                    state_n = S_HALT;
                    hc_n    = '0;
                end
            endcase
        end
    end

    assign stop      = (state != S_RUN);
    assign state_dbg = state;

endmodule

// File: tb/tb_obstacle_filter.sv
// -----------------------------------------------------------------------------
// tb_obstacle_filter
//
// Drives directed and random distance samples into obstacle_filter. Each
// sample is fed to a reference model (a window queue averaged with plain
// arithmetic plus a near/clear streak tracker); the model pushes the expected
// average and resulting stop level into queues that a negedge monitor pops
// whenever avg_vld is seen. Build with +define+OBST_TIMEOUT_EN to include the
// timeout scenario.
// -----------------------------------------------------------------------------
module tb_obstacle_filter;

    localparam int WIDTH    = 20;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;
    localparam int STOP_CM  = 40;
    localparam int CLEAR_CM = 50;
    localparam int HOLD_CNT = 3;
    localparam int TIMEOUT  = 100;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] dist_in = '0;
    logic             dist_vld = 1'b0;
    logic [WIDTH-1:0] dist_avg;
    logic             avg_vld;
    logic             stop;
    logic             fault;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    obstacle_filter #(
        .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .STOP_CM(STOP_CM),
        .CLEAR_CM(CLEAR_CM), .HOLD_CNT(HOLD_CNT), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .dist_in(dist_in), .dist_vld(dist_vld),
        .dist_avg(dist_avg), .avg_vld(avg_vld), .stop(stop), .fault(fault),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_stop_q[$];

    int win_q[$];
    bit m_halt   = 1'b1;
    int m_streak = 0;

    bit   mon_en       = 1'b0;
    bit   stop_pend    = 1'b0;
    logic stop_pend_v  = 1'b1;
    logic exp_stop_cur = 1'b1;
    int   avg_seen     = 0;
    int   run_len      = 0;
    int   max_run      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: average of the last N samples once N have been seen;
    // stop is released after HOLD_CNT consecutive averages >= CLEAR_CM and
    // asserted after HOLD_CNT consecutive averages < STOP_CM.
    task automatic model_sample(input int v);
        int s;
        int a;
        win_q.push_back(v);
        if (win_q.size() > N) void'(win_q.pop_front());
        if (win_q.size() == N) begin
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            a = s / N;
            exp_q.push_back(WIDTH'(a));
            if (m_halt) begin
                m_streak = (a >= CLEAR_CM) ? m_streak + 1 : 0;
            end else begin
                m_streak = (a < STOP_CM) ? m_streak + 1 : 0;
            end
            if (m_streak == HOLD_CNT) begin
                m_halt   = !m_halt;
                m_streak = 0;
            end
            exp_stop_q.push_back(m_halt);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        dist_in  = WIDTH'(v);
        dist_vld = 1'b1;
        model_sample(v);
        @(posedge clk);
        #1;
        dist_vld = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        win_q.delete();
        exp_q.delete();
        exp_stop_q.delete();
        m_halt       = 1'b1;
        m_streak     = 0;
        stop_pend    = 1'b0;
        exp_stop_cur = 1'b1;
        chk("rst_stop", 32'(stop), 1);
        chk("rst_avg_vld", 32'(avg_vld), 0);
        chk("rst_dist_avg", 32'(dist_avg), 0);
        chk("rst_fault", 32'(fault), 0);
        mon_en = 1'b1;
    endtask

    task automatic drain;
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (avg_vld) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            avg_seen++;
        end else begin
            run_len = 0;
        end
        if (mon_en) begin
            if (stop_pend) begin
                exp_stop_cur = stop_pend_v;
                stop_pend    = 1'b0;
            end
            chk("stop_track", 32'(stop), 32'(exp_stop_cur));
            if (avg_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_avg_vld", 32'(avg_vld), 0);
                end else begin
                    chk("dist_avg", 32'(dist_avg), 32'(exp_q.pop_front()));
                    stop_pend_v = exp_stop_q.pop_front();
                    stop_pend   = 1'b1;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen0;
        int v;

        do_reset(3);

        // Warm-up then release: no average on samples 1-3.
        for (int i = 0; i < 3; i++) send(100, 9);
        chk("warmup_no_avg", 32'(avg_seen), 0);
        for (int i = 0; i < 3; i++) send(100, 9);
        drain();
        chk("release_stop", 32'(stop), 0);

        // Approach: 80, 60, 40, 20, 20, 20 -> stop after the third 20.
        for (int i = 0; i < 6; i++) send(20, 4);
        drain();
        chk("approach_stop", 32'(stop), 1);

        // Hysteresis band holds HALT; a single 60 inside 45s is not clear.
        for (int i = 0; i < 10; i++) send(45, 3);
        send(60, 3);
        for (int i = 0; i < 4; i++) send(45, 3);
        drain();
        chk("hyst_stop", 32'(stop), 1);

        // Back to RUN, then reset mid-run.
        for (int i = 0; i < 8; i++) send(100, 2);
        drain();
        chk("run_before_rst", 32'(stop), 0);
        do_reset(1);
        seen0 = avg_seen;
        for (int i = 0; i < 3; i++) send(100, 3);
        drain();
        chk("rst_no_avg_3", 32'(avg_seen - seen0), 0);

        // Back-to-back burst from an empty window: 0,4,...,28.
        do_reset(1);
        seen0   = avg_seen;
        max_run = 0;
        for (int i = 0; i < 8; i++) send(i * 4, 0);
        drain();
        chk("burst_avg_count", 32'(avg_seen - seen0), 5);
        chk("burst_consecutive", 32'(max_run), 5);

        // Random: alternating near/far blocks with mixed gaps.
        do_reset(2);
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 8; i++) begin
                v = (blk % 2 == 1) ? int'($urandom_range(55, 120)) : int'($urandom_range(0, 45));
                send(v, int'($urandom_range(0, 4)));
            end
        end
        drain();
        chk("random_fault_low", 32'(fault), 0);

`ifdef OBST_TIMEOUT_EN
        // Timeout: in RUN, withhold samples after the last one.
        for (int i = 0; i < 7; i++) send(100, 2);
        send(100, 0);
        repeat (99) @(posedge clk);
        #1;
        chk("timeout_fault_before", 32'(fault), 0);
        chk("timeout_stop_before", 32'(stop), 0);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        chk("timeout_fault", 32'(fault), 1);
        chk("timeout_stop", 32'(stop), 1);
        m_halt       = 1'b1;
        m_streak     = 0;
        stop_pend    = 1'b0;
        exp_stop_cur = 1'b1;
        mon_en       = 1'b1;
        send(100, 3);
        chk("fault_cleared", 32'(fault), 0);
        drain();
        chk("stop_after_one_clear", 32'(stop), 1);
        send(100, 3);
        send(100, 3);
        drain();
        chk("stop_after_hold", 32'(stop), 0);
`else
        chk("fault_tied_low", 32'(fault), 0);
`endif

        chk("stop_queue_drained", 32'(exp_stop_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
